// File: rtl/sd_ram_bridge_pkg.sv
// rtl/sd_ram_bridge_pkg.sv - shared state encodings, timeout default and counter sizing
package sd_ram_bridge_pkg;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_ERR    = 2'd3
    } bridge_state_t;

    // Bits needed to hold 0..t; never less than one bit.
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/bridge_timeout_cnt.sv
// rtl/bridge_timeout_cnt.sv - saturating wait counter that flags the last allowed cycle
module bridge_timeout_cnt
    import sd_ram_bridge_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = cnt_width(TIMEOUT)
) (
    input  logic             CLK,
    input  logic             rst_L,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(TIMEOUT);
    localparam logic [CNT_W:0] ONE   = (CNT_W + 1)'(1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_next;

    assign w_next = {1'b0, r_count} + ONE;

    // Count cycles spent waiting; stick at the limit instead of wrapping.
    always_ff @(posedge CLK or negedge rst_L) begin
        if (!rst_L) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && ({1'b0, r_count} < LIMIT)) begin
            r_count <= w_next[CNT_W-1:0];
        end
    end

    // Expired on the cycle whose increment makes the count reach the limit,
    // so the owner leaves its wait state exactly as the count hits TIMEOUT.
    assign expired = enable && !clear && (w_next >= LIMIT);
    assign count   = r_count;

endmodule

// File: rtl/sd_ram_bridge.sv
// rtl/sd_ram_bridge.sv - host request to memory req/gnt/rvalid bridge with timeout and error flags
module sd_ram_bridge
    import sd_ram_bridge_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        CLK,
    input  logic        rst_L,
    input  logic        hst_rd_en,
    input  logic        hst_wr_en,
    input  logic [63:0] hst_addr,
    input  logic [31:0] hst_wdata,
    input  logic        err_clr,
    output logic [31:0] hst_rdata,
    output logic        hst_stop,
    output logic        rd_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err_timeout,
    output logic        err_align,
    output logic        err_overrun
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    bridge_state_t r_state;
    logic [63:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_we;
    logic [31:0]   r_rdata;
    logic          r_mem_req;
    logic          r_hst_stop;
    logic          r_rd_done;
    logic          r_err_timeout;
    logic          r_err_align;
    logic          r_err_overrun;

    logic             w_host_any;
    logic             w_one_op;
    logic             w_accept;
    logic             w_cnt_clear;
    logic             w_cnt_enable;
    logic             w_expired;
    logic [CNT_W-1:0] w_count;
    logic             w_unused_count;

    assign w_host_any = hst_rd_en | hst_wr_en;
    assign w_one_op   = hst_rd_en ^ hst_wr_en;
    assign w_accept   = (r_state == ST_IDLE) && w_one_op && (hst_addr[1:0] == 2'b00);

    // Restart the wait counter whenever REQ or WAIT_R is entered.
    assign w_cnt_clear  = w_accept || ((r_state == ST_REQ) && mem_gnt && !r_we);
    assign w_cnt_enable = (r_state == ST_REQ) || (r_state == ST_WAIT_R);
    assign w_unused_count = ^w_count;

    bridge_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .CLK     (CLK),
        .rst_L   (rst_L),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_enable),
        .count   (w_count),
        .expired (w_expired)
    );

    // Bridge FSM with all host and memory outputs registered.
    always_ff @(posedge CLK or negedge rst_L) begin
        if (!rst_L) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_rdata       <= '0;
            r_mem_req     <= 1'b0;
            r_hst_stop    <= 1'b0;
            r_rd_done     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_align   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_rd_done   <= 1'b0;
            r_err_align <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= hst_addr;
                        r_wdata    <= hst_wdata;
                        r_we       <= hst_wr_en;
                        r_mem_req  <= 1'b1;
                        r_hst_stop <= 1'b1;
                        r_state    <= ST_REQ;
                    end else if (w_host_any) begin
                        // Both enables together, or a misaligned single request.
                        r_err_align <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (w_host_any) begin
                        r_err_overrun <= 1'b1;
                    end
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (r_we) begin
                            r_hst_stop <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_R;
                        end
                    end else if (w_expired) begin
                        r_mem_req     <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_ERR;
                    end
                end
                ST_WAIT_R: begin
                    if (w_host_any) begin
                        r_err_overrun <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        r_rdata    <= mem_rdata;
                        r_rd_done  <= 1'b1;
                        r_hst_stop <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (w_expired) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    if (err_clr) begin
                        r_err_timeout <= 1'b0;
                        r_err_overrun <= 1'b0;
                        r_hst_stop    <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (w_host_any) begin
                        r_err_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_mem_req  <= 1'b0;
                    r_hst_stop <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign hst_rdata   = r_rdata;
    assign hst_stop    = r_hst_stop;
    assign rd_done     = r_rd_done;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign err_timeout = r_err_timeout;
    assign err_align   = r_err_align;
    assign err_overrun = r_err_overrun;

endmodule
